// File: rtl/bmp_stream_writer_if.sv
// Byte-stream writer bus: show-ahead FIFO read side plus valid/ready byte output.
interface bmp_stream_writer_if;
    logic       in_empty;
    logic       in_rd_en;
    logic [7:0] in_dout;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_last;

    // master = the writer (pops the FIFO, drives the stream)
    modport master (
        input  in_empty, in_dout, out_ready,
        output in_rd_en, out_valid, out_byte, out_last
    );

    // slave = FIFO + byte sink environment
    modport slave (
        output in_empty, in_dout, out_ready,
        input  in_rd_en, out_valid, out_byte, out_last
    );
endinterface

// File: rtl/bmp_stream_writer.sv
// Serialises an 8-bit grayscale frame from a show-ahead FIFO into a 24-bit BMP
// byte stream: 54-byte header, then B=G=R pixel triples with 4-byte row padding.
module bmp_stream_writer #(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    bmp_stream_writer_if.master bus
);
    localparam logic [31:0] ROW_BYTES = 32'(IMG_WIDTH) * 32'd3;
    localparam logic [31:0] STRIDE    = ((ROW_BYTES + 32'd3) / 32'd4) * 32'd4;
    localparam logic [31:0] PAD       = STRIDE - ROW_BYTES;
    localparam logic [31:0] IMG_SIZE  = STRIDE * 32'(IMG_HEIGHT);
    localparam logic [31:0] FILE_SIZE = 32'd54 + IMG_SIZE;
    localparam logic [11:0] LAST_COL  = 12'(IMG_WIDTH - 1);
    localparam logic [11:0] LAST_ROW  = 12'(IMG_HEIGHT - 1);
    localparam logic [1:0]  LAST_PAD  = 2'(PAD - 32'd1);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_FETCH, S_PIX, S_PAD} state_t;

    state_t      state;
    logic [5:0]  hdr_idx;
    logic [1:0]  bcnt;
    logic [1:0]  pcnt;
    logic [11:0] col;
    logic [11:0] row;

    logic xfer, last_col, last_row;
    assign xfer     = bus.out_valid && bus.out_ready;
    assign last_col = (col == LAST_COL);
    assign last_row = (row == LAST_ROW);

    // Header byte lookup: pick the 32-bit field covering index i, then its LE byte.
    function automatic logic [7:0] hdr_byte(input logic [5:0] i);
        logic [31:0] f;
        logic [5:0]  base;
        logic [1:0]  off;
        f    = 32'd0;
        base = i;
        case (i) inside
            6'd0:           f = 32'h42;
            6'd1:           f = 32'h4D;
            [6'd2:6'd5]:   begin f = FILE_SIZE; base = 6'd2;  end
            [6'd10:6'd13]: begin f = 32'd54;    base = 6'd10; end
            [6'd14:6'd17]: begin f = 32'd40;    base = 6'd14; end
            [6'd18:6'd21]: begin f = 32'(IMG_WIDTH);  base = 6'd18; end
            [6'd22:6'd25]: begin f = 32'(IMG_HEIGHT); base = 6'd22; end
            [6'd26:6'd27]: begin f = 32'd1;     base = 6'd26; end
            [6'd28:6'd29]: begin f = 32'd24;    base = 6'd28; end
            [6'd34:6'd37]: begin f = IMG_SIZE;  base = 6'd34; end
            [6'd38:6'd41]: begin f = 32'd2835;  base = 6'd38; end
            [6'd42:6'd45]: begin f = 32'd2835;  base = 6'd42; end
            default:        f = 32'd0;
        endcase
        off = 2'(i - base);
        return f[{off, 3'b000} +: 8];
    endfunction

    // Pop is combinational so the FIFO advances on the same edge the pixel is latched;
    // gated by reset so an aborting edge never loses a pixel.
    assign bus.in_rd_en = (state == S_FETCH) && !bus.in_empty && !reset;

    // Frame sequencer; out_byte doubles as the pixel register during PIX.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_byte  <= 8'h00;
            bus.out_last  <= 1'b0;
            hdr_idx       <= '0;
            bcnt          <= '0;
            pcnt          <= '0;
            col           <= '0;
            row           <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // done high means we returned this cycle; a coincident start is dropped
                    if (start && !done) begin
                        state   <= S_HDR;
                        busy    <= 1'b1;
                        hdr_idx <= '0;
                        col     <= '0;
                        row     <= '0;
                    end
                end
                S_HDR: begin
                    if (!bus.out_valid) begin
                        bus.out_byte  <= hdr_byte(hdr_idx);
                        bus.out_valid <= 1'b1;
                        bus.out_last  <= 1'b0;
                    end else if (bus.out_ready) begin
                        if (hdr_idx == 6'd53) begin
                            bus.out_valid <= 1'b0;
                            state         <= S_FETCH;
                        end else begin
                            hdr_idx      <= hdr_idx + 6'd1;
                            bus.out_byte <= hdr_byte(hdr_idx + 6'd1);
                        end
                    end
                end
                S_FETCH: begin
                    if (!bus.in_empty) begin
                        bus.out_byte  <= bus.in_dout;
                        bus.out_valid <= 1'b1;
                        bus.out_last  <= 1'b0;
                        bcnt          <= '0;
                        state         <= S_PIX;
                    end
                end
                S_PIX: begin
                    if (xfer) begin
                        if (bcnt != 2'd2) begin
                            bcnt <= bcnt + 2'd1;
                            // third copy of the final pixel ends the file when rows are unpadded
                            if (bcnt == 2'd1)
                                bus.out_last <= (PAD == 32'd0) && last_row && last_col;
                        end else if (!last_col) begin
                            col           <= col + 12'd1;
                            bus.out_valid <= 1'b0;
                            state         <= S_FETCH;
                        end else if (PAD != 32'd0) begin
                            pcnt          <= '0;
                            bus.out_byte  <= 8'h00;
                            bus.out_last  <= last_row && (PAD == 32'd1);
                            state         <= S_PAD;
                        end else begin
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            if (last_row) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                col   <= '0;
                                row   <= row + 12'd1;
                                state <= S_FETCH;
                            end
                        end
                    end
                end
                S_PAD: begin
                    if (xfer) begin
                        if (pcnt == LAST_PAD) begin
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            if (last_row) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                col   <= '0;
                                row   <= row + 12'd1;
                                state <= S_FETCH;
                            end
                        end else begin
                            pcnt         <= pcnt + 2'd1;
                            bus.out_last <= last_row && ((pcnt + 2'd1) == LAST_PAD);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bmp_stream_writer.sv
// Bench for bmp_stream_writer on a 5x2 frame: table checks, reference-model stream
// compare, random backpressure, FIFO starvation, start glitches and mid-frame reset.
module tb_bmp_stream_writer;
    localparam int W = 5;
    localparam int H = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy, done;

    bmp_stream_writer_if bus();

    bmp_stream_writer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clock(clock), .reset(reset), .start(start),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // FIFO model: show-ahead circular buffer
    logic [7:0] mem [256];
    bit [7:0] rd_ptr = 8'd0;
    bit [7:0] wr_ptr = 8'd0;
    bit hold_empty = 1'b0;
    bit rnd_rdy = 1'b0;
    logic rdy = 1'b1;
    int pop_cnt = 0, empty_pop_err = 0, stab_err = 0, done_cnt = 0;

    assign bus.in_empty  = hold_empty || (rd_ptr == wr_ptr);
    assign bus.in_dout   = mem[rd_ptr];
    assign bus.out_ready = rdy;

    always @(posedge clock) begin
        if (bus.in_rd_en) begin
            if (bus.in_empty) empty_pop_err <= empty_pop_err + 1;
            rd_ptr  <= rd_ptr + 8'd1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    always @(posedge clock) begin
        #1;
        rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Stream monitor: capture transfers, watch hold-while-stalled, count done pulses
    logic [7:0] cap_b[$];
    bit         cap_l[$];
    bit         prev_stall = 1'b0;
    logic [7:0] prev_b = 8'h00;
    logic       prev_l = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!bus.out_valid || bus.out_byte != prev_b || bus.out_last != prev_l))
                stab_err <= stab_err + 1;
            prev_stall <= bus.out_valid && !bus.out_ready;
            prev_b     <= bus.out_byte;
            prev_l     <= bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                cap_b.push_back(bus.out_byte);
                cap_l.push_back(bus.out_last);
            end
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference model: file bytes from the BMP layout rules
    logic [7:0] exp_b[$];

    task automatic push_le(input int v, input int n);
        for (int k = 0; k < n; k++) exp_b.push_back(8'((v >> (8 * k)) & 255));
    endtask

    task automatic build_exp(input bit [7:0] base);
        int stride, pad, isz;
        stride = ((W * 3 + 3) / 4) * 4;
        pad    = stride - W * 3;
        isz    = stride * H;
        exp_b.delete();
        exp_b.push_back(8'h42);
        exp_b.push_back(8'h4D);
        push_le(54 + isz, 4); push_le(0, 4); push_le(54, 4); push_le(40, 4);
        push_le(W, 4); push_le(H, 4); push_le(1, 2); push_le(24, 2);
        push_le(0, 4); push_le(isz, 4); push_le(2835, 4); push_le(2835, 4);
        push_le(0, 4); push_le(0, 4);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                logic [7:0] p;
                p = mem[8'(int'(base) + r * W + c)];
                repeat (3) exp_b.push_back(p);
            end
            repeat (pad) exp_b.push_back(8'h00);
        end
    endtask

    task automatic load(input int n, input bit seq, input logic [7:0] first);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = seq ? 8'(first + 8'(i)) : 8'($urandom_range(0, 255));
            wr_ptr = wr_ptr + 8'd1;
        end
    endtask

    // Run a full frame and compare it against the model
    task automatic run_frame(input bit rnd, input bit glitch, input bit stall);
        bit [7:0] base;
        int cb, dc0, pc0, n, stall_cyc;
        bit got_done;
        base = rd_ptr;
        cb = cap_b.size(); dc0 = done_cnt; pc0 = pop_cnt;
        stall_cyc = 0; got_done = 1'b0;
        build_exp(base);
        rnd_rdy = rnd;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("valid_after_start", int'(bus.out_valid), 0);
        tick();
        chk("first_valid", int'(bus.out_valid), 1);
        chk("first_byte", int'(bus.out_byte), 'h42);
        for (int cyc = 0; cyc < 4000 && !got_done; cyc++) begin
            n = cap_b.size() - cb;
            start = glitch && (n == 10 || n == 60);
            if (stall && n >= 60 && stall_cyc < 20) begin
                hold_empty = 1'b1;
                stall_cyc++;
                if (stall_cyc > 4) begin
                    chk("stall_valid", int'(bus.out_valid), 0);
                    chk("stall_rd_en", int'(bus.in_rd_en), 0);
                end
            end else begin
                hold_empty = 1'b0;
            end
            tick();
            got_done = (done_cnt > dc0);
        end
        start = 1'b0;
        hold_empty = 1'b0;
        chk("done_seen", int'(got_done), 1);
        repeat (3) tick();
        rnd_rdy = 1'b0;
        chk("done_count", done_cnt - dc0, 1);
        chk("busy_end", int'(busy), 0);
        chk("pops", pop_cnt - pc0, W * H);
        n = cap_b.size() - cb;
        chk("byte_count", n, exp_b.size());
        for (int i = 0; i < exp_b.size() && i < n; i++) begin
            chk($sformatf("byte[%0d]", i), int'(cap_b[cb + i]), int'(exp_b[i]));
            chk($sformatf("last[%0d]", i), int'(cap_l[cb + i]), int'(i == exp_b.size() - 1));
        end
    endtask

    typedef struct {
        int         idx;
        logic [7:0] b;
        bit         last;
    } vec_t;

    initial begin
        vec_t tbl[$];
        int cb, dc0, n;
        tbl.push_back('{0, 8'h42, 0});  tbl.push_back('{1, 8'h4D, 0});
        tbl.push_back('{2, 8'h56, 0});  tbl.push_back('{3, 8'h00, 0});
        tbl.push_back('{5, 8'h00, 0});  tbl.push_back('{10, 8'h36, 0});
        tbl.push_back('{14, 8'h28, 0}); tbl.push_back('{18, 8'h05, 0});
        tbl.push_back('{22, 8'h02, 0}); tbl.push_back('{26, 8'h01, 0});
        tbl.push_back('{28, 8'h18, 0}); tbl.push_back('{34, 8'h20, 0});
        tbl.push_back('{38, 8'h13, 0}); tbl.push_back('{39, 8'h0B, 0});
        tbl.push_back('{54, 8'h10, 0}); tbl.push_back('{55, 8'h10, 0});
        tbl.push_back('{56, 8'h10, 0}); tbl.push_back('{69, 8'h00, 0});
        tbl.push_back('{70, 8'h15, 0}); tbl.push_back('{82, 8'h19, 0});
        tbl.push_back('{84, 8'h19, 0}); tbl.push_back('{85, 8'h00, 1});

        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(bus.in_rd_en), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_byte", int'(bus.out_byte), 0);
        chk("rst_last", int'(bus.out_last), 0);
        reset = 1'b0;

        // Frame 1: pixels 0x10..0x19 plus two surplus entries left in the FIFO
        load(10, 1'b1, 8'h10);
        load(2, 1'b1, 8'hEE);
        tick();
        run_frame(1'b0, 1'b0, 1'b0);
        foreach (tbl[i]) begin
            if (tbl[i].idx < cap_b.size()) begin
                chk($sformatf("tbl_byte[%0d]", tbl[i].idx), int'(cap_b[tbl[i].idx]), int'(tbl[i].b));
                chk($sformatf("tbl_last[%0d]", tbl[i].idx), int'(cap_l[tbl[i].idx]), int'(tbl[i].last));
            end else begin
                chk("tbl_missing", 0, 1);
            end
        end

        // Frame 2: random backpressure
        load(10, 1'b0, 8'h00);
        run_frame(1'b1, 1'b0, 1'b0);

        // Frame 3: FIFO starved for 20 cycles mid-row
        load(10, 1'b0, 8'h00);
        run_frame(1'b0, 1'b0, 1'b1);

        // Frame 4: start pulses during header and pixels
        load(10, 1'b0, 8'h00);
        run_frame(1'b0, 1'b1, 1'b0);

        // Reset at byte 40, then a clean restart
        load(10, 1'b0, 8'h00);
        cb = cap_b.size(); dc0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 500 && n < 40; cyc++) begin
            tick();
            n = cap_b.size() - cb;
        end
        chk("reached_byte40", int'(n >= 40), 1);
        reset = 1'b1;
        tick();
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_rd_en", int'(bus.in_rd_en), 0);
        chk("abort_valid", int'(bus.out_valid), 0);
        chk("abort_byte", int'(bus.out_byte), 0);
        chk("abort_last", int'(bus.out_last), 0);
        reset = 1'b0;
        repeat (5) tick();
        chk("abort_no_done", done_cnt - dc0, 0);
        run_frame(1'b0, 1'b0, 1'b0);

        chk("hold_stable", stab_err, 0);
        chk("pop_while_empty", empty_pop_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bmp_stream_writer.md
# bmp_stream_writer

Output-side companion to `edge_detect`. It drains the 8-bit grayscale result FIFO through a show-ahead read interface and serialises a complete 24-bit BMP file as a byte stream with valid/ready handshaking. The stream carries a generated 54-byte header, then each pixel replicated to B=G=R, with row padding to a 4-byte boundary. It sits between the `edge_detect` output FIFO and any byte sink (UART, DMA, file-dump port).

## Interface
- `IMG_WIDTH`, 720, pixels per row (1..4095)
- `IMG_HEIGHT`, 540, rows per frame (1..4095)
- `clock`  in  1  single clock, all logic rising-edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle pulse; begins a frame when idle
- `busy`  out  1  high from the cycle after an accepted `start` until the final byte handshake
- `done`  out  1  one-cycle pulse in the cycle after the final byte handshake
- `in_empty`  in  1  source FIFO empty
- `in_rd_en`  out  1  pop strobe; `in_dout` is valid whenever `in_empty`=0
- `in_dout`  in  8  grayscale pixel (show-ahead)
- `out_valid`  out  1  `out_byte` is valid
- `out_ready`  in  1  sink accepts the byte; a transfer happens when `out_valid`&&`out_ready`
- `out_byte`  out  8  stream byte
- `out_last`  out  1  marks the final byte of the file

## Operation
- Derived constants:
  - STRIDE = ((IMG_WIDTH*3+3)/4)*4
  - PAD = STRIDE - IMG_WIDTH*3 (0..3)
  - IMG_SIZE = STRIDE*IMG_HEIGHT
  - FILE_SIZE = 54 + IMG_SIZE
  - All are 32-bit and computed at elaboration.
- Header bytes, all multi-byte fields little-endian:
  - 0x42 0x4D
  - FILE_SIZE(4)
  - 0(4)
  - 54(4)
  - 40(4)
  - IMG_WIDTH(4)
  - IMG_HEIGHT(4), positive, so rows are bottom-up in input order
  - 1(2)
  - 24(2)
  - 0(4)
  - IMG_SIZE(4)
  - 2835(4)
  - 2835(4)
  - 0(4)
  - 0(4)
- FSM states:
  - IDLE: `start` → HDR. `start` is ignored in every other state.
  - HDR: emits header bytes 0..53 under a 6-bit index. After byte 53 transfers → FETCH.
  - FETCH: waits for `in_empty`=0. Asserts `in_rd_en` for one cycle and latches `in_dout` into the pixel register → PIX.
  - PIX: emits the pixel register three times under a 2-bit byte counter.
    - On the handshake of the third byte with the column count not at the end of the row → FETCH.
    - At the end of the row: PAD>0 → PAD; otherwise row end processing.
  - PAD: emits PAD bytes of 0x00, then row end processing.
  - Row end processing: if this was the last row → IDLE and pulse `done`; otherwise clear the column count, increment the row count → FETCH.
- Counters: column 0..IMG_WIDTH-1 and row 0..IMG_HEIGHT-1, both 12-bit.
- `in_rd_en` is asserted only in FETCH with `in_empty`=0. It is never asserted while empty, never outside a frame, and at most once per pixel.
- Exactly IMG_WIDTH*IMG_HEIGHT FIFO pops per frame. Surplus FIFO data stays unread.
- `out_last` = 1 only on byte FILE_SIZE-1. This is the last pad byte, or the last pixel byte if PAD = 0.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `in_rd_en`=0, `out_valid`=0, `out_byte`=0x00, `out_last`=0
  - state IDLE, all counters 0
- `reset` mid-frame aborts to IDLE on the next edge. There is no `done` pulse, and the source FIFO is not flushed.
- Output register rule: once `out_valid`=1, `out_byte` and `out_last` hold stable until the handshake cycle. `out_valid` never drops without a transfer.
- `start` sampled at edge N → `out_valid`=1 with `out_byte`=0x42 after edge N+1.
- Header throughput with `out_ready`=1: one byte per cycle, 54 cycles.
- Pixel cost: one FETCH cycle plus three PIX bytes, so 4 cycles per pixel when the FIFO is non-empty and `out_ready`=1. Pad bytes cost one cycle each.
- Stall conditions:
  - `in_empty`=1 in FETCH: `out_valid`=0 until data arrives.
  - `out_ready`=0: the FSM holds, with no counter or FIFO activity.
- `done` asserts in the cycle after the `out_last` handshake, concurrent with return to IDLE and `busy`=0.
- A `start` coincident with `done` is ignored. The next frame requires `start` while in IDLE.

## Test plan
- Defaults, `out_ready`=1, FIFO preloaded with 388800 pixels:
  - Header bytes 2..5 = 76 CC 11 00; bytes 18..21 = D0 02 00 00; bytes 22..25 = 1C 02 00 00; bytes 34..37 = 40 CC 11 00.
  - 1166454 bytes total, `out_last` only on the last, one `done` pulse.
  - The output file compares clean against the golden Sobel BMP.
- IMG_WIDTH=5, IMG_HEIGHT=2, pixels 0x10..0x19:
  - 86 bytes total; STRIDE=16.
  - Byte 54..56 = 10 10 10; byte 69 = 0x00 pad.
  - Bytes 82..84 = 19 19 19; byte 85 = 00 with `out_last`=1.
- Random `out_ready` (50%) on the 5×2 frame:
  - Identical byte sequence.
  - `out_byte` is never changed while `out_valid`&&!`out_ready`.
- FIFO empty for 20 cycles mid-row:
  - `out_valid`=0 and `in_rd_en`=0 throughout.
  - Resumes with the correct next pixel; 10 pops total.
- `reset` at byte 40 of the 5×2 frame:
  - All outputs return to reset values next cycle; no `done`.
  - A new `start` restarts with 0x42.
- `start` pulsed during HDR and PIX: ignored, frame unchanged, exactly one `done`.
